// File: rtl/riscv_v_rf_scoreboard.sv
// VRF/MRF write-hazard scoreboard: per-register pending-write counters, combinational ID stall, registered sb_empty.
// Optional RISCV_V_SB_WB_BYPASS_EN lets a single pending write retiring this cycle satisfy a RAW read.
module riscv_v_rf_scoreboard #(
    parameter int NUM_VREGS   = 32,
    parameter int NUM_MREGS   = 8,
    parameter int MAX_PENDING = 3,
    localparam int VA_W = $clog2(NUM_VREGS),
    localparam int MA_W = $clog2(NUM_MREGS),
    localparam int CW   = $clog2(MAX_PENDING + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic [VA_W-1:0] issue_vs1,
    input  logic            issue_vs1_used,
    input  logic [VA_W-1:0] issue_vs2,
    input  logic            issue_vs2_used,
    input  logic [VA_W-1:0] issue_vd,
    input  logic            issue_vd_wr,
    input  logic            issue_vm_used,
    input  logic [MA_W-1:0] issue_vm,
    input  logic [MA_W-1:0] issue_md,
    input  logic            issue_md_wr,
    input  logic            wb_vd_wr,
    input  logic [VA_W-1:0] wb_vd,
    input  logic            wb_md_wr,
    input  logic [MA_W-1:0] wb_md,
    output logic            hazard_stall,
    output logic            issue_fire,
    output logic            sb_empty
);

    logic [CW-1:0] vcnt_q [NUM_VREGS];
    logic [CW-1:0] vcnt_d [NUM_VREGS];
    logic [CW-1:0] mcnt_q [NUM_MREGS];
    logic [CW-1:0] mcnt_d [NUM_MREGS];
    logic          sb_empty_q;
    logic          sb_empty_d;

    logic [CW-1:0] vs1_cnt, vs2_cnt, vd_cnt, vm_cnt, md_cnt;
    logic          vs1_byp, vs2_byp, vm_byp;
    logic          raw_hz, struct_hz;

    assign vs1_cnt = vcnt_q[issue_vs1];
    assign vs2_cnt = vcnt_q[issue_vs2];
    assign vd_cnt  = vcnt_q[issue_vd];
    assign vm_cnt  = mcnt_q[issue_vm];
    assign md_cnt  = mcnt_q[issue_md];

`ifdef RISCV_V_SB_WB_BYPASS_EN
    // Last outstanding write lands this cycle; the RF write-through read returns it.
    assign vs1_byp = wb_vd_wr && (wb_vd == issue_vs1) && (vs1_cnt == CW'(1));
    assign vs2_byp = wb_vd_wr && (wb_vd == issue_vs2) && (vs2_cnt == CW'(1));
    assign vm_byp  = wb_md_wr && (wb_md == issue_vm)  && (vm_cnt  == CW'(1));
`else
    assign vs1_byp = 1'b0;
    assign vs2_byp = 1'b0;
    assign vm_byp  = 1'b0;
`endif

    assign raw_hz = (issue_vs1_used && (vs1_cnt != '0) && !vs1_byp)
                  | (issue_vs2_used && (vs2_cnt != '0) && !vs2_byp)
                  | (issue_vm_used  && (vm_cnt  != '0) && !vm_byp);

    assign struct_hz = (issue_vd_wr && (vd_cnt == CW'(MAX_PENDING)))
                     | (issue_md_wr && (md_cnt == CW'(MAX_PENDING)));

    assign hazard_stall = issue_valid && (raw_hz || struct_hz);
    assign issue_fire   = issue_valid && !hazard_stall && !stall && !flush;
    assign sb_empty     = sb_empty_q;

    // WB decrements are not gated by stall; a decrement at zero is dropped rather than wrapping.
    always_comb begin
        logic inc, dec;
        sb_empty_d = 1'b1;
        for (int i = 0; i < NUM_VREGS; i++) begin
            inc = issue_fire && issue_vd_wr && (issue_vd == VA_W'(i));
            dec = wb_vd_wr && (wb_vd == VA_W'(i)) && (vcnt_q[i] != '0);
            vcnt_d[i] = vcnt_q[i];
            if (flush)             vcnt_d[i] = '0;
            else if (inc && !dec)  vcnt_d[i] = vcnt_q[i] + CW'(1);
            else if (dec && !inc)  vcnt_d[i] = vcnt_q[i] - CW'(1);
            if (vcnt_d[i] != '0)   sb_empty_d = 1'b0;
        end
        for (int j = 0; j < NUM_MREGS; j++) begin
            inc = issue_fire && issue_md_wr && (issue_md == MA_W'(j));
            dec = wb_md_wr && (wb_md == MA_W'(j)) && (mcnt_q[j] != '0);
            mcnt_d[j] = mcnt_q[j];
            if (flush)             mcnt_d[j] = '0;
            else if (inc && !dec)  mcnt_d[j] = mcnt_q[j] + CW'(1);
            else if (dec && !inc)  mcnt_d[j] = mcnt_q[j] - CW'(1);
            if (mcnt_d[j] != '0)   sb_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VREGS; i++) vcnt_q[i] <= '0;
            for (int j = 0; j < NUM_MREGS; j++) mcnt_q[j] <= '0;
            sb_empty_q <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_VREGS; i++) vcnt_q[i] <= vcnt_d[i];
            for (int j = 0; j < NUM_MREGS; j++) mcnt_q[j] <= mcnt_d[j];
            sb_empty_q <= sb_empty_d;
        end
    end

`ifdef RISCV_V_SB_UNDERFLOW_CHK
    // A WB with nothing pending means the staged enables and the scoreboard disagree.
    always_ff @(posedge clk) begin
        if (rst && !flush && wb_vd_wr)
            assert (vcnt_q[wb_vd] != '0) else $error("VRF scoreboard underflow on v%0d", wb_vd);
        if (rst && !flush && wb_md_wr)
            assert (mcnt_q[wb_md] != '0) else $error("MRF scoreboard underflow on m%0d", wb_md);
    end
`endif

endmodule

// File: tb/tb_riscv_v_rf_scoreboard.sv
// Directed self-checking bench for riscv_v_rf_scoreboard; expectations follow RISCV_V_SB_WB_BYPASS_EN if defined.
module tb_riscv_v_rf_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, flush, issue_valid;
    logic [4:0] issue_vs1, issue_vs2, issue_vd, wb_vd;
    logic       issue_vs1_used, issue_vs2_used, issue_vd_wr, issue_vm_used, issue_md_wr;
    logic [2:0] issue_vm, issue_md, wb_md;
    logic       wb_vd_wr, wb_md_wr;
    logic       hazard_stall, issue_fire, sb_empty;

    int checks = 0;
    int errors = 0;

`ifdef RISCV_V_SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    riscv_v_rf_scoreboard dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .issue_valid(issue_valid),
        .issue_vs1(issue_vs1), .issue_vs1_used(issue_vs1_used),
        .issue_vs2(issue_vs2), .issue_vs2_used(issue_vs2_used),
        .issue_vd(issue_vd), .issue_vd_wr(issue_vd_wr),
        .issue_vm_used(issue_vm_used), .issue_vm(issue_vm),
        .issue_md(issue_md), .issue_md_wr(issue_md_wr),
        .wb_vd_wr(wb_vd_wr), .wb_vd(wb_vd), .wb_md_wr(wb_md_wr), .wb_md(wb_md),
        .hazard_stall(hazard_stall), .issue_fire(issue_fire), .sb_empty(sb_empty)
    );

    task automatic idle();
        stall = 0; flush = 0; issue_valid = 0;
        issue_vs1 = 0; issue_vs2 = 0; issue_vd = 0; issue_vm = 0; issue_md = 0;
        issue_vs1_used = 0; issue_vs2_used = 0; issue_vd_wr = 0; issue_vm_used = 0; issue_md_wr = 0;
        wb_vd_wr = 0; wb_vd = 0; wb_md_wr = 0; wb_md = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        #12;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
        checks++;
        if (hazard_stall !== 1'b0 || issue_fire !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got stall=%b fire=%b exp 0/0", hazard_stall, issue_fire);
        end
        #4 rst = 1;
        tick();
    endtask

    task automatic test_raw();
        int stalls = 0;
        idle(); issue_valid = 1; issue_vd = 3; issue_vd_wr = 1; #1;
        checks++;
        if (issue_fire !== 1'b1 || hazard_stall !== 1'b0) begin
            errors++; $display("FAIL raw_first_write got fire=%b stall=%b exp 1/0", issue_fire, hazard_stall);
        end
        tick();
        idle(); issue_valid = 1; issue_vs1 = 3; issue_vs1_used = 1; #1;
        checks++;
        if (sb_empty !== 1'b0) begin errors++; $display("FAIL raw_sb_busy got=%b exp=0", sb_empty); end
        for (int c = 0; c < 3; c++) begin
            if (hazard_stall === 1'b1) stalls++;
            tick();
        end
        wb_vd_wr = 1; wb_vd = 3; #1;
        if (hazard_stall === 1'b1) stalls++;
        checks++;
        if (issue_fire !== BYP) begin errors++; $display("FAIL raw_wb_cycle_fire got=%b exp=%b", issue_fire, BYP); end
        tick();
        wb_vd_wr = 0;
        if (BYP) issue_valid = 0;
        #1;
        if (hazard_stall === 1'b1) stalls++;
        checks++;
        if (issue_fire !== !BYP) begin errors++; $display("FAIL raw_after_wb_fire got=%b exp=%b", issue_fire, !BYP); end
        checks++;
        if (stalls !== (BYP ? 3 : 4)) begin errors++; $display("FAIL raw_stall_cycles got=%0d exp=%0d", stalls, BYP ? 3 : 4); end
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL raw_sb_empty got=%b exp=1", sb_empty); end
        tick();
        idle();
    endtask

    task automatic test_structural();
        idle(); issue_valid = 1; issue_vd = 5; issue_vd_wr = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (issue_fire !== 1'b1) begin errors++; $display("FAIL struct_fill%0d got fire=%b exp=1", c, issue_fire); end
            tick();
        end
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("FAIL struct_full got stall=%b exp=1", hazard_stall); end
        tick();
        wb_vd_wr = 1; wb_vd = 5; #1;
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("FAIL struct_wb_cycle got stall=%b exp=1", hazard_stall); end
        tick();
        wb_vd_wr = 0; #1;
        checks++;
        if (hazard_stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL struct_after_wb got stall=%b fire=%b exp 0/1", hazard_stall, issue_fire);
        end
        tick();
        idle(); wb_vd_wr = 1; wb_vd = 5;
        tick(); tick(); tick();
        idle(); #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL struct_drained got sb_empty=%b exp=1", sb_empty); end
    endtask

    task automatic test_same_cycle();
        idle(); issue_valid = 1; issue_vd = 7; issue_vd_wr = 1;
        tick();
        wb_vd_wr = 1; wb_vd = 7; #1;
        checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL same_fire got=%b exp=1", issue_fire); end
        tick();
        idle(); issue_valid = 1; issue_vs1 = 7; issue_vs1_used = 1; #1;
        checks++;
        if (sb_empty !== 1'b0 || hazard_stall !== 1'b1) begin
            errors++; $display("FAIL same_pending got sb_empty=%b stall=%b exp 0/1", sb_empty, hazard_stall);
        end
        tick();
        idle(); wb_vd_wr = 1; wb_vd = 7;
        tick();
        idle(); #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL same_single_wb got sb_empty=%b exp=1", sb_empty); end
    endtask

    task automatic test_flush();
        idle(); issue_valid = 1; issue_vd_wr = 1; issue_vd = 1;
        tick();
        issue_vd = 2;
        tick();
        idle(); issue_valid = 1; issue_md_wr = 1; issue_md = 0;
        tick();
        idle(); flush = 1; issue_valid = 1; issue_vd = 9; issue_vd_wr = 1; #1;
        checks++;
        if (issue_fire !== 1'b0 || sb_empty !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got fire=%b sb_empty=%b exp 0/0", issue_fire, sb_empty);
        end
        tick();
        idle(); issue_valid = 1; issue_vs1 = 1; issue_vs1_used = 1; issue_vm_used = 1; issue_vm = 0; #1;
        checks++;
        if (sb_empty !== 1'b1 || hazard_stall !== 1'b0 || issue_fire !== 1'b1) begin
            errors++; $display("FAIL flush_after got sb_empty=%b stall=%b fire=%b exp 1/0/1", sb_empty, hazard_stall, issue_fire);
        end
        tick();
        idle();
    endtask

    task automatic test_mask();
        idle(); issue_valid = 1; issue_md_wr = 1; issue_md = 2;
        tick();
        idle(); issue_valid = 1; issue_vm_used = 1; issue_vm = 2; #1;
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("FAIL mask_raw got stall=%b exp=1", hazard_stall); end
        issue_vm = 3; #1;
        checks++;
        if (issue_fire !== 1'b1 || hazard_stall !== 1'b0) begin
            errors++; $display("FAIL mask_other got fire=%b stall=%b exp 1/0", issue_fire, hazard_stall);
        end
        tick();
        idle(); wb_md_wr = 1; wb_md = 2;
        tick();
        idle(); #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL mask_drained got sb_empty=%b exp=1", sb_empty); end
    endtask

    task automatic test_ext_stall();
        idle(); issue_valid = 1; issue_vd = 10; issue_vd_wr = 1;
        tick();
        idle(); issue_valid = 1; issue_vs2 = 10; issue_vs2_used = 1; #1;
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("FAIL vs2_raw got stall=%b exp=1", hazard_stall); end
        issue_vs2_used = 0; stall = 1; #1;
        checks++;
        if (hazard_stall !== 1'b0 || issue_fire !== 1'b0) begin
            errors++; $display("FAIL ext_stall got stall=%b fire=%b exp 0/0", hazard_stall, issue_fire);
        end
        issue_valid = 0; wb_vd_wr = 1; wb_vd = 10;
        tick();
        idle(); #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL ext_wb_during_stall got sb_empty=%b exp=1", sb_empty); end
    endtask

    task automatic test_async_reset();
        idle(); issue_valid = 1; issue_vd = 4; issue_vd_wr = 1;
        tick(); tick();
        idle(); #1;
        checks++;
        if (sb_empty !== 1'b0) begin errors++; $display("FAIL areset_pre got sb_empty=%b exp=0", sb_empty); end
        #1 rst = 0;
        #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL areset_clear got sb_empty=%b exp=1", sb_empty); end
        issue_valid = 1; issue_vs1 = 4; issue_vs1_used = 1; #1;
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("FAIL areset_read got stall=%b exp=0", hazard_stall); end
        idle(); #1 rst = 1;
        tick();
        wb_vd_wr = 1; wb_vd = 4;
        tick();
        idle(); issue_valid = 1; issue_vs1 = 4; issue_vs1_used = 1; #1;
        checks++;
        if (hazard_stall !== 1'b0 || issue_fire !== 1'b1 || sb_empty !== 1'b1) begin
            errors++; $display("FAIL areset_spurious_wb got stall=%b fire=%b sb_empty=%b exp 0/1/1", hazard_stall, issue_fire, sb_empty);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_structural();
        test_same_cycle();
        test_flush();
        test_mask();
        test_ext_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_v_rf_scoreboard.md
Name: riscv_v_rf_scoreboard

Overview:
- Hazard scoreboard for the vector register file (VRF) and the mask register file (MRF).
- Tracks in-flight writes from issue (ID) to writeback (WB), and stalls ID when a source or destination conflicts with a pending write.
- Sits beside the ID→EXE→WB staging of VRF/MRF addresses and enables.
- Its hazard_stall output is ORed into the global pipeline stall by the vector top level.

Parameters:
- NUM_VREGS, 32, number of vector registers; address width is $clog2(NUM_VREGS).
- NUM_MREGS, 8, number of mask registers; address width is $clog2(NUM_MREGS).
- MAX_PENDING, 3, maximum in-flight writes per register; equals RISCV_V_ID_2_WB_LATENCY. Counter width is $clog2(MAX_PENDING+1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  external pipeline stall, excluding this block's own output.
- flush  in  1  pipeline flush; all in-flight writes are cancelled.
- issue_valid  in  1  ID holds a valid vector instruction.
- issue_vs1  in  VA_W  vector source A address.
- issue_vs1_used  in  1  source A is read.
- issue_vs2  in  VA_W  vector source B address.
- issue_vs2_used  in  1  source B is read.
- issue_vd  in  VA_W  vector destination address.
- issue_vd_wr  in  1  instruction writes the VRF.
- issue_vm_used  in  1  instruction reads mask register issue_vm.
- issue_vm  in  MA_W  mask source address.
- issue_md  in  MA_W  mask destination address.
- issue_md_wr  in  1  instruction writes the MRF.
- wb_vd_wr  in  1  VRF write occurs at WB (OR of rf_wr_en_wb bytes).
- wb_vd  in  VA_W  VRF WB address.
- wb_md_wr  in  1  MRF write occurs at WB.
- wb_md  in  MA_W  MRF WB address.
- hazard_stall  out  1  ID must hold this cycle.
- issue_fire  out  1  instruction accepted this cycle.
- sb_empty  out  1  no pending writes anywhere.

Behaviour:
- State: one counter per VRF register (vcnt[NUM_VREGS]) and one per MRF register (mcnt[NUM_MREGS]). No other state.
- Reset (rst=0, asynchronous):
  - All counters go to 0.
  - sb_empty=1.
  - hazard_stall and issue_fire are combinational from the counters; both are 0 while issue_valid=0.
- RAW hazard: any of
  - issue_vs1_used and vcnt[vs1]≠0
  - issue_vs2_used and vcnt[vs2]≠0
  - issue_vm_used and mcnt[vm]≠0
- Structural hazard: any of
  - issue_vd_wr and vcnt[vd]==MAX_PENDING
  - issue_md_wr and mcnt[md]==MAX_PENDING
- WAW does not stall. WB is in order, so repeated destinations only increment the counter.
- hazard_stall = issue_valid & (RAW | structural). It is combinational, with no latency.
- issue_fire = issue_valid & ~hazard_stall & ~stall & ~flush.
- Counter update at posedge clk:
  - +1 on vcnt[vd] when issue_fire & issue_vd_wr.
  - −1 on vcnt[wb_vd] when wb_vd_wr. Decrement is not gated by stall, because WB has already committed.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
  - MRF counters follow the same rules with md/wb_md.
- flush: all counters cleared to 0 next cycle. Flush takes priority over issue and WB in the same cycle, since the staged enables are flushed.
- Underflow (WB to a counter at 0): counter stays 0; flagged by assertion, never wraps.
- Overflow cannot occur because of the structural hazard check.
- sb_empty is a registered OR-reduce: 1 when all counters are 0 after the update.
- Reset asserted mid-operation clears all state immediately; the first post-reset issue sees no hazard.

Optional Feature:
- Macro: RISCV_V_SB_WB_BYPASS_EN.
- Defined: a RAW source whose counter is exactly 1 and which matches the WB address in the same cycle (wb_vd_wr/wb_md_wr) is not a hazard. This relies on the RF write-through read.
- Undefined: any nonzero counter stalls, and the instruction issues one cycle later.

Test Plan:
- Issue v3 write (vd=3) then, next cycle, v3 read (vs1=3) → hazard_stall=1 for 3 cycles. Counter returns to 0 on wb_vd_wr (wb_vd=3), then issue_fire=1. Without the macro, one extra stall cycle versus with it.
- Three back-to-back writes to v5 → vcnt[5]=3. A fourth write to v5 → hazard_stall=1 (structural), cleared the cycle after the first WB to v5.
- Issue write v7 with wb_vd_wr to v7 in the same cycle (vcnt[7]=1) → vcnt[7] stays 1, sb_empty=0.
- Pending writes to v1, v2 and mask m0, then flush=1 → all counters 0 next cycle, sb_empty=1, a read of v1 issues with no stall.
- Mask write m2 pending; instruction with issue_vm_used=1, vm=2 → hazard_stall=1. The same instruction with vm=3 → issue_fire=1.
- rst=0 asynchronously while vcnt[4]=2 → counters clear without a clock edge, sb_empty=1, and a spurious wb_vd_wr to v4 after reset keeps vcnt[4]=0.
